// File: rtl/md_unit_pkg.sv
// Shared opcode and state encodings for the E-stage multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath working on the latched operands.
import md_unit_pkg::*;

module md_calc (
  input  logic [31:0] a_q,
  input  logic [31:0] b_q,
  input  md_op_t      op_q,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    is_signed = md_is_signed(op_q);
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_ext     = {{32{a_neg}}, a_q};
    b_ext     = {{32{b_neg}}, b_q};
    // Low 64 bits of the extended product are the same for signed and unsigned.
    prod      = a_ext * b_ext;

    // Magnitude divide keeps 0x8000_0000 / -1 well defined: it yields q = 0x8000_0000, r = 0.
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    if (b_mag == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end

    hi_res = prod[63:32];
    lo_res = prod[31:0];
    if (op_q == MD_DIV || op_q == MD_DIVU) begin
      if (b_q == 32'd0) begin
        hi_res = a_q;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        lo_res = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        hi_res = a_neg ? (32'd0 - ur) : ur;
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with its own HI/LO registers and MTHI/MTLO writes.
import md_unit_pkg::*;

module md_unit #(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mt_en,
  input  logic        mt_sel,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output md_state_t   state_dbg
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  md_op_t             op_q;
  logic [31:0]        hi_res;
  logic [31:0]        lo_res;

  md_calc u_calc (
    .a_q    (a_q),
    .b_q    (b_q),
    .op_q   (op_q),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  // Handshake: start/mt_en are accepted only in IDLE; while busy the hazard unit
  // holds them low, and any request seen during RUN is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MULT;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= md_op_t'(md_op);
            cnt   <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state <= MD_RUN;
            busy  <= 1'b1;
          end else if (mt_en) begin
            if (mt_sel) HI <= A;
            else        LO <= A;
          end
        end
        MD_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            HI    <= hi_res;
            LO    <= lo_res;
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign md_hazard = start | busy;
  assign state_dbg = state;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: cycle-level reference model plus hand-computed checkpoints.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic [1:0]  md_op;
  logic        mt_en;
  logic        mt_sel;
  logic        busy;
  logic        md_hazard;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        state_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .start     (start),
    .md_op     (md_op),
    .mt_en     (mt_en),
    .mt_sel    (mt_sel),
    .busy      (busy),
    .md_hazard (md_hazard),
    .HI        (HI),
    .LO        (LO),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_result(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      2'b10: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          q  = $signed(a) / $signed(b);
          r  = $signed(a) % $signed(b);
          lo = q;
          hi = r;
        end
      end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // The model tracks edges: an op accepted at edge E commits its result at edge E+N.
  logic        m_pend = 1'b0;
  int          m_edge = 0;
  int          m_done = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] m_rhi  = '0;
  logic [31:0] m_rlo  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_edge++;
      if (m_pend) begin
        if (m_edge == m_done) begin
          m_hi   = m_rhi;
          m_lo   = m_rlo;
          m_pend = 1'b0;
        end
      end else if (start) begin
        ref_result(md_op, A, B, m_rhi, m_rlo);
        m_done = m_edge + (md_op[1] ? DIV_N : MULT_N);
        m_pend = 1'b1;
      end else if (mt_en) begin
        if (mt_sel) m_hi = A;
        else        m_lo = A;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("md_hazard", {31'd0, md_hazard}, {31'd0, start | m_pend});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("req_while_busy", {31'd0, busy & (start | mt_en)}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  logic [31:0] lit_hi;
  logic [31:0] lit_lo;

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic with_mt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_n);
    int n;
    A      = a;
    B      = b;
    md_op  = op;
    start  = 1'b1;
    mt_en  = with_mt;
    mt_sel = 1'b1;
    #1;
    chk({name, "_hazard_idle"}, {31'd0, md_hazard}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    mt_en = 1'b0;
    A     = 32'hDEAD_BEEF;
    B     = 32'hCAFE_F00D;
    chk({name, "_state_run"}, {31'd0, state_dbg}, 32'd1);
    chk({name, "_hi_hold"}, HI, lit_hi);
    chk({name, "_lo_hold"}, LO, lit_lo);
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_busy_cycles"}, n, exp_n);
    chk({name, "_hi"}, HI, exp_hi);
    chk({name, "_lo"}, LO, exp_lo);
    lit_hi = exp_hi;
    lit_lo = exp_lo;
  endtask

  task automatic mt_write(input string name, input logic sel, input logic [31:0] val);
    A      = val;
    mt_en  = 1'b1;
    mt_sel = sel;
    @(posedge clk);
    #1;
    mt_en = 1'b0;
    if (sel) lit_hi = val;
    else     lit_lo = val;
    chk({name, "_hi"}, HI, lit_hi);
    chk({name, "_lo"}, LO, lit_lo);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b0;
    A      = '0;
    B      = '0;
    start  = 1'b0;
    md_op  = 2'b00;
    mt_en  = 1'b0;
    mt_sel = 1'b0;
    lit_hi = '0;
    lit_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult_neg",   2'b00, 32'hFFFF_FFFE, 32'd3,          1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N);
    run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'd2,          1'b0, 32'h0000_0001, 32'hFFFF_FFFE, MULT_N);
    run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'd2,          1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
    run_op("div_negdvs", 2'b10, 32'd7,         32'hFFFF_FFFE,  1'b0, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N);
    run_op("divu_zero",  2'b11, 32'h0000_1234, 32'd0,          1'b0, 32'h0000_1234, 32'hFFFF_FFFF, DIV_N);
    run_op("div_zero",   2'b10, 32'hFFFF_FF00, 32'd0,          1'b0, 32'hFFFF_FF00, 32'hFFFF_FFFF, DIV_N);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 32'h8000_0000, DIV_N);
    run_op("divu_big",   2'b11, 32'hFFFF_FFFF, 32'd10,         1'b0, 32'h0000_0005, 32'h1999_9999, DIV_N);
    run_op("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000,  1'b0, 32'h4000_0000, 32'h0000_0000, MULT_N);

    mt_write("mthi", 1'b1, 32'hA5A5_A5A5);
    mt_write("mtlo", 1'b0, 32'h5A5A_5A5A);

    // start and mt_en together: the multiply runs and HI is not overwritten with A.
    run_op("start_mt",   2'b01, 32'd3,         32'd5,          1'b1, 32'h0000_0000, 32'h0000_000F, MULT_N);

    // Abort a divide with an asynchronous reset between clock edges.
    A     = 32'd100;
    B     = 32'd7;
    md_op = 2'b10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hazard", {31'd0, md_hazard}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    lit_hi = '0;
    lit_lo = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult_after", 2'b00, 32'd3,         32'd4,          1'b0, 32'h0000_0000, 32'h0000_000C, MULT_N);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
